// File: rtl/cv32e40p_x_result_buffer_if.sv
// Result channel bundle shared by the coprocessor-to-buffer side and the
// buffer-to-writeback side. Both directions carry the same x_result fields.
//   valid   : producer has a result on the bus
//   ready   : consumer accepts the result this cycle
//   id      : offload instruction ID
//   data    : result data
//   rd      : destination register
//   we      : register write enable
//   exc     : synchronous exception
//   exccode : exception code
// The master modport is the producer side; the slave modport is the consumer side.
interface cv32e40p_x_result_buffer_if #(
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFW_WIDTH = 32
);
   logic                   valid;
   logic                   ready;
   logic [X_ID_WIDTH-1:0]  id;
   logic [X_RFW_WIDTH-1:0] data;
   logic [4:0]             rd;
   logic                   we;
   logic                   exc;
   logic [5:0]             exccode;

   modport master (output valid, id, data, rd, we, exc, exccode, input ready);
   modport slave  (input valid, id, data, rd, we, exc, exccode, output ready);
endinterface

// File: rtl/cv32e40p_x_result_buffer.sv
// Core-side receive stage for the CORE-V-XIF result channel. Coprocessor
// results are buffered in a small in-order FIFO and handed to writeback,
// which may stall. Result IDs are checked against offload order and the
// whole buffer can be flushed.
// Ports:
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   res         : incoming result channel (slave side)
//   wb          : head entry toward writeback (master side)
//   flush_i     : discard all buffered results
//   flush_id_i  : next expected ID after a flush
//   count_o     : current occupancy
//   id_err_o    : sticky flag, an out-of-order result ID was accepted
module cv32e40p_x_result_buffer #(
   parameter int DEPTH       = 2,
   parameter int X_ID_WIDTH  = 4,
   parameter int X_RFW_WIDTH = 32,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   cv32e40p_x_result_buffer_if.slave  res,
   cv32e40p_x_result_buffer_if.master wb,
   input  logic                   flush_i,
   input  logic [X_ID_WIDTH-1:0]  flush_id_i,
   output logic [CW-1:0]          count_o,
   output logic                   id_err_o
);

   typedef struct packed {
      logic [X_ID_WIDTH-1:0]  id;
      logic [X_RFW_WIDTH-1:0] data;
      logic [4:0]             rd;
      logic                   we;
      logic                   exc;
      logic [5:0]             exccode;
   } entry_t;

   entry_t                mem [DEPTH];
   entry_t                head;
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count;
   logic [X_ID_WIDTH-1:0] exp_id;
   logic                  id_err;
   logic                  push, pop;

   // Pointers wrap at DEPTH-1 so any depth works, not only powers of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready and valid come from the occupancy register only, so there is no
   // combinational path from wb.ready back to res.ready.
   assign res.ready = (count != CW'(DEPTH));
   assign wb.valid  = (count != '0);
   assign push      = res.valid & res.ready;
   assign pop       = wb.valid & wb.ready;

   assign head       = mem[rd_ptr];
   assign wb.id      = head.id;
   assign wb.data    = head.data;
   assign wb.rd      = head.rd;
   assign wb.we      = head.we;
   assign wb.exc     = head.exc;
   assign wb.exccode = head.exccode;

   assign count_o  = count;
   assign id_err_o = id_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         exp_id <= '0;
         id_err <= 1'b0;
      end else if (flush_i) begin
         // A push in the flush cycle still handshakes but is dropped and not
         // ID-checked; a pop in the same cycle is discarded as well.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         exp_id <= flush_id_i;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{res.id, res.data, res.rd, res.we, res.exc, res.exccode};
            wr_ptr      <= ptr_inc(wr_ptr);
            if (res.id != exp_id) id_err <= 1'b1;
            // Track the following ID even after a mismatch so one bad result
            // does not cascade into errors on every later result.
            exp_id <= res.id + 1'b1;
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule
